// File: rtl/comparator_pkg.sv
// Shared types and constants for the serial magnitude comparator.
// Holds the FSM state encoding, default operand width and index-width helper.
package comparator_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int idx_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/bit_compare_cell.sv
// Single-bit magnitude decision, purely combinational.
// Ports: a, b (bits under test), invert (swap gt/lt for a sign bit),
//        gt, eq, lt (one-hot decision).
module bit_compare_cell (
    input  logic a,
    input  logic b,
    input  logic invert,
    output logic gt,
    output logic eq,
    output logic lt
);

    logic w_a_hi;
    logic w_b_hi;

    assign w_a_hi = a & ~b;
    assign w_b_hi = ~a & b;
    assign eq     = ~(a ^ b);
    // On a sign bit a set bit means "more negative", so the sense flips.
    assign gt     = invert ? w_b_hi : w_a_hi;
    assign lt     = invert ? w_a_hi : w_b_hi;

endmodule

// File: rtl/serial_comparator_nbit.sv
// Bit-serial MSB-first comparator of two WIDTH-bit operands with early exit.
// Ports: CLK, RST (async, active-high), START, A, B in; BUSY, DONE, GT, EQ, LT
//        out. Macro SIGNED_MODE_EN adds input SIGNED (two's-complement compare).
module serial_comparator_nbit
    import comparator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
`ifdef SIGNED_MODE_EN
    input  logic             SIGNED,
`endif
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic             GT,
    output logic             EQ,
    output logic             LT
);

    localparam int IW = idx_width(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic             r_done;
    logic             r_gt;
    logic             r_eq;
    logic             r_lt;
    logic             w_load;
    logic             w_shift;
    logic             w_finish;
    logic             w_inv;
    logic             w_gt;
    logic             w_eq;
    logic             w_lt;
    logic             w_last;

    assign w_last = (r_idx == '0);

`ifdef SIGNED_MODE_EN
    logic r_signed;

    // Only the first bit examined (the MSB) is a sign bit.
    assign w_inv = r_signed & (r_idx == IW'(WIDTH - 1));
`else
    assign w_inv = 1'b0;
`endif

    // Operands shift left, so the bit under test is always the MSB.
    bit_compare_cell u_cell (
        .a      (r_a[WIDTH-1]),
        .b      (r_b[WIDTH-1]),
        .invert (w_inv),
        .gt     (w_gt),
        .eq     (w_eq),
        .lt     (w_lt)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_finish    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (START) begin
                    w_load      = 1'b1;
                    w_state_nxt = COMPARE;
                end
            end
            COMPARE: begin
                if (!w_eq || w_last) begin
                    w_finish    = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_shift = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_a    <= '0;
            r_b    <= '0;
            r_idx  <= IW'(WIDTH - 1);
            r_done <= 1'b0;
            r_gt   <= 1'b0;
            r_eq   <= 1'b0;
            r_lt   <= 1'b0;
`ifdef SIGNED_MODE_EN
            r_signed <= 1'b0;
`endif
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_a   <= A;
                r_b   <= B;
                r_idx <= IW'(WIDTH - 1);
`ifdef SIGNED_MODE_EN
                r_signed <= SIGNED;
`endif
            end else if (w_shift) begin
                r_a   <= r_a << 1;
                r_b   <= r_b << 1;
                r_idx <= r_idx - IW'(1);
            end
            if (w_finish) begin
                r_gt <= w_gt;
                r_eq <= w_eq;
                r_lt <= w_lt;
            end
        end
    end

    assign BUSY = (r_state == COMPARE);
    assign DONE = r_done;
    assign GT   = r_gt;
    assign EQ   = r_eq;
    assign LT   = r_lt;

endmodule

// File: doc/serial_comparator_nbit.md
SERIAL_COMPARATOR_NBIT -- requirements
Module: serial_comparator_nbit

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..64.
REQ-002 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Port: RST  input  1  reset, asynchronous, active-high.
REQ-004 Port: START  input  1  request to compare A and B; sampled only in IDLE.
REQ-005 Port: A  input  WIDTH  operand A; captured on accepted START.
REQ-006 Port: B  input  WIDTH  operand B; captured on accepted START.
REQ-007 Port: BUSY  output  1  high while FSM in COMPARE.
REQ-008 Port: DONE  output  1  one-cycle pulse marking a new valid result.
REQ-009 Port: GT, EQ, LT  output  1 each  registered result, one-hot when valid, held until next DONE.

Function
REQ-010 FSM SHALL have two states, IDLE and COMPARE; encoding defined in package.
REQ-011 IDLE and START=1 at a rising edge: SHALL capture A, B into internal shift registers, load bit index WIDTH-1, enter COMPARE, set BUSY=1.
REQ-012 IDLE and START=0: SHALL remain in IDLE; outputs unchanged, DONE=0.
REQ-013 COMPARE: one bit per cycle, MSB first; each edge compares the bits at the current index.
REQ-014 Bits differ (early exit): SHALL set GT=1 if A bit=1, else LT=1; EQ=0; DONE=1; BUSY=0; return to IDLE, all on that edge.
REQ-015 Bits equal and index>0: SHALL decrement index and stay in COMPARE; GT/EQ/LT unchanged.
REQ-016 Bits equal and index=0: SHALL set EQ=1, GT=LT=0, DONE=1, BUSY=0, return to IDLE.
REQ-017 Latency: DONE SHALL assert k+1 edges after the START-sampling edge, where k = (WIDTH - index of first differing bit); worst case WIDTH+1 edges, best case 2.
REQ-018 DONE SHALL be high for exactly one cycle per accepted START.
REQ-019 START while BUSY=1 SHALL be ignored; A/B changes during COMPARE SHALL NOT affect the result.
REQ-020 START=1 in the DONE cycle SHALL be accepted (FSM is already IDLE), giving back-to-back operation without a gap cycle.
REQ-021 Before the first result after reset, GT=EQ=LT=0; afterwards exactly one of them SHALL be 1.

Reset
REQ-022 RST=1 SHALL immediately force IDLE, BUSY=0, DONE=0, GT=0, EQ=0, LT=0, index=WIDTH-1, shift registers=0.
REQ-023 RST asserted mid-COMPARE SHALL abort the operation; no DONE pulse SHALL follow the release of reset.
REQ-024 First START SHALL be accepted on the first rising edge after RST deasserts.

Configuration
REQ-025 Macro SIGNED_MODE_EN, when defined, SHALL add port SIGNED (input, 1 bit, captured with the operands on accepted START).
REQ-026 With SIGNED_MODE_EN and SIGNED=1, the MSB (sign bit) comparison SHALL be inverted (A MSB=1, B MSB=0 gives LT); bits below the MSB SHALL compare unsigned as before.
REQ-027 Without SIGNED_MODE_EN, the SIGNED port SHALL NOT exist and all comparisons SHALL be unsigned.

Structure
REQ-028 Package comparator_pkg SHALL hold the FSM state typedef/encoding, the default WIDTH constant, and the index width function (clog2 of WIDTH).
REQ-029 Per-bit decision SHALL be a sub-module bit_compare_cell (inputs a, b, invert; outputs gt, eq, lt; purely combinational), instanced once.
REQ-030 Sequencing, capture and result registers SHALL live in serial_comparator_nbit.

Verification (WIDTH=8)
REQ-031 A=8'h00, B=8'h00, START 1 cycle -> BUSY for 8 cycles; DONE on edge 9 after START; EQ=1, GT=LT=0.
REQ-032 A=8'h80, B=8'h7F -> DONE on edge 2, GT=1; with SIGNED_MODE_EN and SIGNED=1 -> LT=1.
REQ-033 A=8'h12, B=8'h13 -> DONE on edge 9, LT=1; result then held while START=0 for 5 cycles.
REQ-034 START with A=8'h05, B=8'h03; START again at edge 1 with A=8'h01, B=8'hFF -> second START ignored, GT=1 from first operation.
REQ-035 RST pulsed during COMPARE of A=8'h01, B=8'h01 at edge 4 -> all outputs 0 immediately; no DONE within 12 cycles.
REQ-036 A=8'hF0, B=8'h0F, then START held high in DONE cycle with A=8'h0F, B=8'hF0 -> DONE GT=1, then next DONE 2 edges later with LT=1.
